// File: rtl/riscv_alu.sv
// Registered 32-bit RV32I execute-stage ALU with one cycle of latency.
// Optional carry/overflow outputs are enabled with the ALU_OVERFLOW_FLAG_EN macro.
module riscv_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        b_negate,
  input  logic        b_add_one,
  input  logic        sign,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic        carry_flag,
  output logic        overflow_flag,
`endif
  output logic [31:0] out,
  output logic        zero_flag
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  logic [31:0] b_eff;
  logic        carry_in;
  logic [31:0] sum;
  logic [4:0]  shamt;
  logic [31:0] result;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        carry_out;
  logic        carry_next;
  logic        overflow_next;
`endif

  assign shamt = b[4:0];

  // Modifiers only apply to the adder path; every other op sees raw b.
  always_comb begin
    b_eff    = b;
    carry_in = 1'b0;
    if (op == OP_ADD) begin
      if (b_negate) b_eff = ~b;
      carry_in = b_add_one;
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {32'd0, carry_in};
`else
  assign sum = a + b_eff + {31'd0, carry_in};
`endif

  always_comb begin
    result = 32'd0;
    case (op)
      OP_ADD:  result = sum;
      OP_SLL:  result = a << shamt;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: result = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  result = a ^ b;
      OP_SR:   result = sign ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = 32'd0;
    endcase
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  always_comb begin
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    if (op == OP_ADD) begin
      carry_next    = carry_out;
      overflow_next = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 32'd0;
      zero_flag <= 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
`endif
    end else begin
      out       <= result;
      zero_flag <= (result == 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
      carry_flag    <= carry_next;
      overflow_flag <= overflow_next;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu; carry/overflow checks are included when
// ALU_OVERFLOW_FLAG_EN is defined.
module tb_riscv_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_negate;
  logic        b_add_one;
  logic        sign;
  logic [31:0] out;
  logic        zero_flag;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        carry_flag;
  logic        overflow_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_exp;

  riscv_alu dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .a         (a),
    .b         (b),
    .b_negate  (b_negate),
    .b_add_one (b_add_one),
    .sign      (sign),
`ifdef ALU_OVERFLOW_FLAG_EN
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
`endif
    .out       (out),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one vector at the falling edge, confirm out has not moved yet,
  // then confirm the result one rising edge later.
  task automatic apply(input string tag, input logic [2:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic neg, input logic add1,
                       input logic sg, input logic [31:0] exp, input logic c,
                       input logic v);
    @(negedge clk);
    op = o; a = va; b = vb; b_negate = neg; b_add_one = add1; sign = sg;
    #1;
    check({tag, "_hold"}, out, prev_exp);
    @(posedge clk);
    #1;
    check(tag, out, exp);
    check({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, (exp == 32'd0)});
`ifdef ALU_OVERFLOW_FLAG_EN
    check({tag, "_carry"}, {31'd0, carry_flag}, {31'd0, c});
    check({tag, "_ovf"}, {31'd0, overflow_flag}, {31'd0, v});
`else
    if (c === 1'bx || v === 1'bx) $display("note: unexpected x flag argument in %s", tag);
`endif
    prev_exp = exp;
  endtask

  initial begin
    rst = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    b_negate = 1'b0; b_add_one = 1'b0; sign = 1'b0;
    prev_exp = 32'd0;

    // Async reset before any clock edge has happened.
    #2 rst = 1'b1;
    #1;
    check("rst_out_async", out, 32'd0);
    check("rst_zero_async", {31'd0, zero_flag}, 32'd1);
    @(negedge clk);
    check("rst_out_hold", out, 32'd0);
    check("rst_zero_hold", {31'd0, zero_flag}, 32'd1);
    rst = 1'b0;

    apply("add_30_20",   3'b000, 32'd30, 32'd20, 1'b0, 1'b0, 1'b0, 32'd50, 1'b0, 1'b0);
    apply("sub_30_20",   3'b000, 32'd30, 32'd20, 1'b1, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0);
    apply("sub_20_20",   3'b000, 32'd20, 32'd20, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0);
    apply("sll_1_2",     3'b001, 32'd1,  32'd2,  1'b0, 1'b0, 1'b0, 32'd4,  1'b0, 1'b0);
    apply("slt_m10_10",  3'b010, 32'hFFFF_FFF6, 32'd10, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    apply("sltu_m10_10", 3'b011, 32'hFFFF_FFF6, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    apply("slt_10_m10",  3'b010, 32'd10, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    apply("sltu_10_m10", 3'b011, 32'd10, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    apply("srl_ff_2",    3'b101, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, 32'h3FFF_FFFF, 1'b0, 1'b0);
    apply("sra_ff_2",    3'b101, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply("srl_ff_22",   3'b101, 32'hFFFF_FFFF, 32'h22, 1'b0, 1'b0, 1'b0, 32'h3FFF_FFFF, 1'b0, 1'b0);
    apply("sra_80_22",   3'b101, 32'h8000_0000, 32'h22, 1'b0, 1'b0, 1'b1, 32'hE000_0000, 1'b0, 1'b0);
    apply("srl_80_22",   3'b101, 32'h8000_0000, 32'h22, 1'b0, 1'b0, 1'b0, 32'h2000_0000, 1'b0, 1'b0);
    apply("xor_m10_10",  3'b100, 32'hFFFF_FFF6, 32'd10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    apply("or_m1_2",     3'b110, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply("and_m1_2",    3'b111, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    apply("add_ovf",     3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    apply("add_wrap",    3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    apply("sll_by_0",    3'b001, 32'h0000_1234, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    apply("xor_nomod",   3'b100, 32'h0000_00F0, 32'h0F, 1'b1, 1'b1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    apply("sll_nosign",  3'b001, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    apply("sr_mod_ign",  3'b101, 32'h0000_0100, 32'd4, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0);

    // Mid-stream reset: the pending result is dropped and out clears at once.
    @(negedge clk);
    op = 3'b111; a = 32'h0000_00FF; b = 32'h0000_000F;
    b_negate = 1'b0; b_add_one = 1'b0; sign = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", out, 32'd0);
    check("mid_rst_zero", {31'd0, zero_flag}, 32'd1);
    @(posedge clk);
    #1;
    check("mid_rst_hold", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_nocap", out, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_first", out, 32'h0000_000F);
    check("post_rst_zero", {31'd0, zero_flag}, 32'd0);
    prev_exp = 32'h0000_000F;

    apply("add_after_rst", 3'b000, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion before 20000");
    $fatal(1);
  end

endmodule
